instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Fetch/decode stage that sits opposite `program_sequencer`. It latches the instruction the sequencer addressed and decodes it into the sequencer's jump controls and the datapath's register-load, source-select and ALU controls. It holds the zero flag that drives `dont_jmp`. It also generates the sequencer's `sync_reset` from the block's asynchronous reset.

## Interface
No parameters.
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pm_data`  in  8  program-memory read data at `pm_addr`; memory read is asynchronous
- `alu_zero`  in  1  ALU result-is-zero, valid in any cycle with `alu_en`=1
- `sync_reset`  out  1  synchronized reset to `program_sequencer`
- `ir`  out  8  instruction register, always holds the instruction at `pc`
- `jmp`  out  1  unconditional jump request
- `jmp_nz`  out  1  jump-if-not-zero request
- `jmp_addr`  out  4  jump target high nibble, equal to `ir[3:0]`
- `dont_jmp`  out  1  registered zero flag; suppresses `jmp_nz`
- `NOPC8`, `NOPCF`, `NOPD8`, `NOPDF`  out  1 each  `ir` equals 8'hC8 / 8'hCF / 8'hD8 / 8'hDF
- `reg_en`  out  8  one-hot load enable, destination registers 0–7
- `src_sel`  out  4  datapath source: 0–7 select a register, 8 selects immediate `ir[3:0]`
- `alu_en`  out  1  ALU instruction executing
- `alu_func`  out  4  ALU function, equal to `ir[3:0]`
- `x_sel`  out  1  ALU X-operand select, equal to `ir[4]`

## Operation
- **Reset synchronizer.** Two flops `s1` and `s2`.
  - `reset`=1 sets both to 1 asynchronously.
  - Otherwise `s1`<=0 and `s2`<=`s1`.
  - `sync_reset`=`s2`: asserts immediately and deasserts on the 2nd rising edge after `reset` falls.
- **Instruction register.**
  - `reset`=1 forces `ir`=8'hC8 asynchronously.
  - Otherwise `ir`<=`pm_data` on every edge, including edges while `sync_reset`=1. The sequencer holds `pm_addr`=0 during `sync_reset`, so the first decoded instruction is address 0.
- **Zero flag `z`.**
  - `reset` clears `z` to 0 asynchronously.
  - On an edge where `alu_en`=1, `z`<=`alu_zero`; otherwise `z` holds.
  - `dont_jmp`=`z`.
- **Decode.** All decode is combinational from `ir`. While `sync_reset`=1, `reg_en`, `jmp`, `jmp_nz` and `alu_en` are forced to 0.
  - `ir[7]`=0, load immediate: `reg_en`[`ir[6:4]`]=1, `src_sel`=8.
  - `ir[7:6]`=2'b10, move: `src_sel`={0,`ir[2:0]`} and `reg_en`[`ir[5:3]`]=1. If `ir[5:3]`==`ir[2:0]`, `reg_en`=0 (null move).
  - `ir[7:4]`=4'hC: `jmp`=1.
  - `ir[7:4]`=4'hD: `jmp_nz`=1.
  - `ir[7:4]`=4'hE or 4'hF: `alu_en`=1. `reg_en`=0 because the ALU loads its own result register.
  - Reserved NOPs 8'hC8, 8'hCF, 8'hD8, 8'hDF: the matching `NOPxx`=1, and `jmp`, `jmp_nz`, `reg_en` and `alu_en` are all 0.
  - For non-move, non-load instructions, `src_sel`=0.
- The `NOPxx` outputs, `jmp_addr`, `alu_func` and `x_sel` are never gated by `sync_reset`.

## Timing
- **Reset values.**
  - `sync_reset`=1, `ir`=8'hC8, `dont_jmp`=0.
  - `NOPC8`=1; all other `NOPxx`=0.
  - `jmp`=`jmp_nz`=`alu_en`=0, `reg_en`=0, `src_sel`=0.
  - `jmp_addr`=8, `alu_func`=8, `x_sel`=0.
- **Pipeline.** `ir` always holds the instruction at the sequencer's `pc`. A taken jump in cycle n loads the target instruction at edge n+1, with zero bubbles and no flush.
- **Flag latency.** `dont_jmp` reflects an ALU result from the next cycle onward.
- **Back-to-back ALU→jnz.** A `jnz` immediately after an ALU instruction sees that ALU instruction's flag.
- **Reset mid-operation.** Asserting `reset` immediately (no clock needed) forces `ir`=8'hC8, clears `z` and asserts `sync_reset`. Any ALU update in progress is lost.
- **ALU during synchronized reset.** An ALU instruction in `ir` while `sync_reset`=1 does not update `z`, because `alu_en` is gated to 0.

## Test plan
1. Reset high 3 cycles with rom[0]=8'h15, then release:
   - During reset: `ir`=8'hC8, `NOPC8`=1.
   - `sync_reset` falls on the 2nd edge after release.
   - Next cycle: `ir`=8'h15, `reg_en`=8'h02, `src_sel`=8.
2. `ir`=8'h9A → `reg_en`=8'h08, `src_sel`=2. `ir`=8'h92 → `reg_en`=8'h00, `src_sel`=2.
3. `ir`=8'hC5 → `jmp`=1, `jmp_addr`=5. `ir`=8'hC8 → `jmp`=0, `NOPC8`=1. `ir`=8'hDF → `jmp_nz`=0, `NOPDF`=1.
4. Flag sequence:
   - `ir`=8'hE3 with `alu_zero`=1 → `alu_en`=1, `alu_func`=3, `x_sel`=0.
   - Next cycle: `dont_jmp`=1; then `ir`=8'hD4 gives `jmp_nz`=1, `dont_jmp`=1.
   - `ir`=8'hF1 with `alu_zero`=0 → `x_sel`=1; `dont_jmp`=0 the following cycle.
5. With `dont_jmp`=1, toggle `alu_zero` during loads and moves (8'h27, 8'h9A) → `dont_jmp` stays 1.
6. With `dont_jmp`=1 and `ir`=8'hE0, assert `reset` between edges → `dont_jmp`=0, `sync_reset`=1, `ir`=8'hC8 immediately, `alu_en`=0.

Source files
------------

// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
//
// Fetch/decode stage paired with program_sequencer. Each clock it latches the
// program-memory word the sequencer is addressing into the instruction
// register. It decodes that word into jump requests for the sequencer and
// register-load, source-select and ALU controls for the datapath. It also
// keeps the zero flag used to suppress jnz. The sequencer's synchronous reset
// is derived here from the asynchronous block reset.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous active-high reset
//   pm_data     in   8-bit program-memory read data
//   alu_zero    in   ALU result-is-zero, meaningful while alu_en=1
//   sync_reset  out  synchronized reset for program_sequencer
//   ir          out  8-bit instruction register
//   jmp         out  unconditional jump request
//   jmp_nz      out  jump-if-not-zero request
//   jmp_addr    out  4-bit jump target high nibble (ir[3:0])
//   dont_jmp    out  registered zero flag, suppresses jmp_nz
//   NOPC8/NOPCF/NOPD8/NOPDF  out  reserved-NOP indicators
//   reg_en      out  8-bit one-hot destination register load enable
//   src_sel     out  4-bit datapath source (0-7 register, 8 immediate)
//   alu_en      out  ALU instruction executing
//   alu_func    out  4-bit ALU function (ir[3:0])
//   x_sel       out  ALU X-operand select (ir[4])
// ---------------------------------------------------------------------------
module instruction_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       sync_reset,
  output logic [7:0] ir,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp,
  output logic       NOPC8,
  output logic       NOPCF,
  output logic       NOPD8,
  output logic       NOPDF,
  output logic [7:0] reg_en,
  output logic [3:0] src_sel,
  output logic       alu_en,
  output logic [3:0] alu_func,
  output logic       x_sel
);

  logic       s1;
  logic       s2;
  logic       z;
  logic       is_nop;
  logic [7:0] reg_en_raw;
  logic       jmp_raw;
  logic       jmp_nz_raw;
  logic       alu_en_raw;

  // Two-flop reset synchronizer: asserts immediately, releases on the second
  // rising edge after reset falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= 1'b0;
      s2 <= s1;
    end
  end

  assign sync_reset = s2;

  // The instruction register loads every edge, even during sync_reset. The
  // sequencer parks pm_addr at 0 then, so address 0 is decoded first. The
  // reset value C8 is a reserved NOP, so nothing acts on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= 8'hC8;
    end else begin
      ir <= pm_data;
    end
  end

  // The zero flag follows the ALU only while an ALU instruction is actually
  // executing. alu_en is gated by sync_reset, so an ALU opcode fetched during
  // the synchronized reset cannot disturb the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z <= 1'b0;
    end else if (alu_en) begin
      z <= alu_zero;
    end
  end

  assign dont_jmp = z;

  // Reserved NOP encodings live inside the jmp/jnz opcode space. They must
  // suppress the jump they would otherwise decode to.
  assign NOPC8  = (ir == 8'hC8);
  assign NOPCF  = (ir == 8'hCF);
  assign NOPD8  = (ir == 8'hD8);
  assign NOPDF  = (ir == 8'hDF);
  assign is_nop = NOPC8 | NOPCF | NOPD8 | NOPDF;

  // Opcode decode. ir[7]=0 is load-immediate, 10 is register move, and 11
  // splits into jmp (C), jnz (D) and ALU (E/F). A move whose destination equals
  // its source is a null move and loads nothing. ALU ops leave reg_en clear
  // because the ALU writes its own result register.
  always_comb begin
    reg_en_raw = 8'h00;
    src_sel    = 4'd0;
    jmp_raw    = 1'b0;
    jmp_nz_raw = 1'b0;
    alu_en_raw = 1'b0;
    case (ir[7:6])
      2'b00, 2'b01: begin
        reg_en_raw = 8'h01 << ir[6:4];
        src_sel    = 4'd8;
      end
      2'b10: begin
        src_sel = {1'b0, ir[2:0]};
        if (ir[5:3] != ir[2:0]) begin
          reg_en_raw = 8'h01 << ir[5:3];
        end
      end
      default: begin
        case (ir[5:4])
          2'b00:   jmp_raw    = ~is_nop;
          2'b01:   jmp_nz_raw = ~is_nop;
          default: alu_en_raw = 1'b1;
        endcase
      end
    endcase
  end

  // Anything that changes machine state is held off during sync_reset. The
  // field extracts and NOP flags are left ungated.
  assign reg_en   = sync_reset ? 8'h00 : reg_en_raw;
  assign jmp      = jmp_raw    & ~sync_reset;
  assign jmp_nz   = jmp_nz_raw & ~sync_reset;
  assign alu_en   = alu_en_raw & ~sync_reset;

  assign jmp_addr = ir[3:0];
  assign alu_func = ir[3:0];
  assign x_sel    = ir[4];

endmodule

// File: tb/tb_instruction_decoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_decoder
//
// Directed bench for instruction_decoder. A behavioural model tracks the
// instruction register, the zero flag and the edges since reset release. It
// derives the expected controls from the instruction classes. A negedge
// process compares every DUT output with the model each cycle. The main
// sequence adds hand-computed literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_instruction_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       sync_reset;
  logic [7:0] ir;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic       NOPC8;
  logic       NOPCF;
  logic       NOPD8;
  logic       NOPDF;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic       alu_en;
  logic [3:0] alu_func;
  logic       x_sel;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 0;

  instruction_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .pm_data    (pm_data),
    .alu_zero   (alu_zero),
    .sync_reset (sync_reset),
    .ir         (ir),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .dont_jmp   (dont_jmp),
    .NOPC8      (NOPC8),
    .NOPCF      (NOPCF),
    .NOPD8      (NOPD8),
    .NOPDF      (NOPDF),
    .reg_en     (reg_en),
    .src_sel    (src_sel),
    .alu_en     (alu_en),
    .alu_func   (alu_func),
    .x_sel      (x_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: instruction held, zero flag, and edges seen since reset fell.
  logic [7:0] m_ir;
  logic       m_z;
  int         m_rel;

  function automatic bit m_is_alu(input logic [7:0] ins);
    return int'(ins) >= 224;
  endfunction

  // While reset is high m_rel stays 0, so the sync test is just m_rel < 2.
  function automatic bit m_sync();
    return m_rel < 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ir  <= 8'hC8;
      m_z   <= 1'b0;
      m_rel <= 0;
    end else begin
      if (!m_sync() && m_is_alu(m_ir)) m_z <= alu_zero;
      m_ir <= pm_data;
      if (m_rel < 2) m_rel <= m_rel + 1;
    end
  end

  typedef struct packed {
    logic       jmp;
    logic       jmp_nz;
    logic       alu_en;
    logic [7:0] reg_en;
    logic [3:0] src_sel;
    logic [3:0] nops;
  } ctrl_t;

  // Expected controls derived from opcode ranges with plain arithmetic.
  function automatic ctrl_t model_decode(input logic [7:0] ins, input bit sync);
    ctrl_t c;
    int v;
    int dst;
    int src;
    bit nop;
    v   = int'(ins);
    c   = '0;
    nop = (v == 200) || (v == 207) || (v == 216) || (v == 223);
    c.nops = {v == 223, v == 216, v == 207, v == 200};
    if (v < 128) begin
      c.reg_en  = 8'(1 << (v / 16));
      c.src_sel = 4'd8;
    end else if (v < 192) begin
      dst       = (v / 8) % 8;
      src       = v % 8;
      c.src_sel = 4'(src);
      c.reg_en  = (dst == src) ? 8'h00 : 8'(1 << dst);
    end else if (v / 16 == 12) begin
      c.jmp = !nop;
    end else if (v / 16 == 13) begin
      c.jmp_nz = !nop;
    end else begin
      c.alu_en = 1'b1;
    end
    if (sync) begin
      c.jmp    = 1'b0;
      c.jmp_nz = 1'b0;
      c.alu_en = 1'b0;
      c.reg_en = 8'h00;
    end
    return c;
  endfunction

  task automatic cmp(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Full comparison of every DUT output against the model.
  task automatic checkOutput();
    ctrl_t e;
    e = model_decode(m_ir, m_sync());
    cmp("ir",         int'(ir),         int'(m_ir));
    cmp("sync_reset", int'(sync_reset), int'(m_sync()));
    cmp("dont_jmp",   int'(dont_jmp),   int'(m_z));
    cmp("jmp",        int'(jmp),        int'(e.jmp));
    cmp("jmp_nz",     int'(jmp_nz),     int'(e.jmp_nz));
    cmp("alu_en",     int'(alu_en),     int'(e.alu_en));
    cmp("reg_en",     int'(reg_en),     int'(e.reg_en));
    cmp("src_sel",    int'(src_sel),    int'(e.src_sel));
    cmp("nops",       int'({NOPDF, NOPD8, NOPCF, NOPC8}), int'(e.nops));
    cmp("jmp_addr",   int'(jmp_addr),   int'(m_ir) % 16);
    cmp("alu_func",   int'(alu_func),   int'(m_ir) % 16);
    cmp("x_sel",      int'(x_sel),      (int'(m_ir) / 16) % 2);
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  // Drives pm_data for the next fetch. az is the ALU zero result for the
  // instruction currently in ir, sampled at the same edge. Returns 1 ns
  // after that edge.
  task automatic applyStimulus(input logic [7:0] pm, input logic az);
    @(negedge clk);
    #2;
    pm_data  = pm;
    alu_zero = az;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] extra_prog [10] = '{8'h00, 8'h7F, 8'hBF, 8'hB6, 8'hCF,
                                  8'hD8, 8'hE9, 8'hD2, 8'hFA, 8'h41};
  logic       extra_az   [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    reset    = 1'b0;
    pm_data  = 8'h15;
    alu_zero = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    cmp("rst_ir",       int'(ir),         8'hC8);
    cmp("rst_nopc8",    int'(NOPC8),      1);
    cmp("rst_sync",     int'(sync_reset), 1);
    cmp("rst_dont_jmp", int'(dont_jmp),   0);
    cmp("rst_jmp_addr", int'(jmp_addr),   8);
    cmp("rst_alu_func", int'(alu_func),   8);
    cmp("rst_src_sel",  int'(src_sel),    0);
    cmp("rst_reg_en",   int'(reg_en),     0);
    check_en = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    cmp("rst_hold_ir", int'(ir), 8'hC8);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("sync_edge1",   int'(sync_reset), 1);
    cmp("gated_reg_en", int'(reg_en),     0);
    @(posedge clk);
    #1;
    cmp("sync_edge2", int'(sync_reset), 0);
    cmp("ld_ir",      int'(ir),         8'h15);
    cmp("ld_reg_en",  int'(reg_en),     8'h02);
    cmp("ld_src_sel", int'(src_sel),    8);

    applyStimulus(8'h9A, 1'b0);
    cmp("mv_reg_en",  int'(reg_en),  8'h08);
    cmp("mv_src_sel", int'(src_sel), 2);
    applyStimulus(8'h92, 1'b0);
    cmp("null_reg_en",  int'(reg_en),  8'h00);
    cmp("null_src_sel", int'(src_sel), 2);

    applyStimulus(8'hC5, 1'b0);
    cmp("jmp_c5",   int'(jmp),      1);
    cmp("jaddr_c5", int'(jmp_addr), 5);
    applyStimulus(8'hC8, 1'b0);
    cmp("jmp_c8", int'(jmp),   0);
    cmp("nopc8",  int'(NOPC8), 1);
    applyStimulus(8'hDF, 1'b0);
    cmp("jnz_df", int'(jmp_nz), 0);
    cmp("nopdf",  int'(NOPDF),  1);

    applyStimulus(8'hE3, 1'b0);
    cmp("alu_en_e3",   int'(alu_en),   1);
    cmp("alu_func_e3", int'(alu_func), 3);
    cmp("x_sel_e3",    int'(x_sel),    0);
    applyStimulus(8'hD4, 1'b1);
    cmp("jnz_d4",       int'(jmp_nz),   1);
    cmp("flag_after_e3", int'(dont_jmp), 1);
    applyStimulus(8'hF1, 1'b1);
    cmp("x_sel_f1",   int'(x_sel),    1);
    cmp("flag_hold",  int'(dont_jmp), 1);
    applyStimulus(8'h27, 1'b0);
    cmp("flag_after_f1", int'(dont_jmp), 0);

    applyStimulus(8'hE5, 1'b0);
    applyStimulus(8'h27, 1'b1);
    cmp("flag_set_e5", int'(dont_jmp), 1);
    applyStimulus(8'h9A, 1'b0);
    cmp("flag_ld_az0", int'(dont_jmp), 1);
    applyStimulus(8'h27, 1'b1);
    cmp("flag_mv_az1", int'(dont_jmp), 1);
    applyStimulus(8'hE0, 1'b0);
    cmp("flag_ld_az0b", int'(dont_jmp), 1);
    cmp("alu_en_e0",    int'(alu_en),   1);

    #2;
    reset = 1'b1;
    #1;
    cmp("mid_dont_jmp", int'(dont_jmp),   0);
    cmp("mid_sync",     int'(sync_reset), 1);
    cmp("mid_ir",       int'(ir),         8'hC8);
    cmp("mid_alu_en",   int'(alu_en),     0);

    // Release with an ALU op at address 0: it must not touch the flag while
    // sync_reset is still high.
    pm_data  = 8'hE7;
    alu_zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp("sync_alu_gated", int'(alu_en), 0);
    @(posedge clk);
    #1;
    cmp("sync_alu_noflag", int'(dont_jmp), 0);
    cmp("alu_after_sync",  int'(alu_en),   1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(extra_prog[i], extra_az[i]);
    end
    applyStimulus(8'h00, 1'b0);

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
